// File: rtl/calc_ctrl.sv
// Moore controller for the 3-bit calculator datapath: loads A and B, executes one ALU op, presents the result.
// Optional register-file clear sequence is enabled by defining CTRL_CLEAR_EN.
module calc_ctrl #(
    parameter logic [1:0] RA_A = 2'd1,
    parameter logic [1:0] RA_B = 2'd2,
    parameter logic [1:0] RA_Y = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
`ifdef CTRL_CLEAR_EN
    input  logic       clr,
`endif
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic [1:0] s1,
    output logic       we,
    output logic [1:0] wa,
    output logic       rea,
    output logic [1:0] raa,
    output logic       reb,
    output logic [1:0] rab,
    output logic [1:0] c,
    output logic       s2
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;
`ifdef CTRL_CLEAR_EN
    localparam logic [2:0] CLR    = 3'd5;
`endif

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] op_q;
`ifdef CTRL_CLEAR_EN
    logic [1:0] cnt;
`endif

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                state_nxt = IDLE;
`ifdef CTRL_CLEAR_EN
                if (clr)
                    state_nxt = CLR;
                else if (go)
                    state_nxt = LOAD_A;
`else
                if (go)
                    state_nxt = LOAD_A;
`endif
            end
            LOAD_A: state_nxt = LOAD_B;
            LOAD_B: state_nxt = EXEC;
            EXEC:   state_nxt = OUT;
            OUT:    state_nxt = IDLE;
`ifdef CTRL_CLEAR_EN
            CLR:    state_nxt = (cnt == 2'd3) ? IDLE : CLR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // op is captured only on the accepting edge so later changes cannot disturb a running operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= 2'b00;
`ifdef CTRL_CLEAR_EN
            cnt   <= 2'd0;
`endif
        end else begin
            state <= state_nxt;
`ifdef CTRL_CLEAR_EN
            if (state == IDLE && !clr && go)
                op_q <= op;
            if (state == CLR)
                cnt <= cnt + 2'd1;
            else
                cnt <= 2'd0;
`else
            if (state == IDLE && go)
                op_q <= op;
`endif
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = 1'b0;
        s1   = 2'b01;
        we   = 1'b0;
        wa   = 2'd0;
        rea  = 1'b0;
        raa  = 2'd0;
        reb  = 1'b0;
        rab  = 2'd0;
        c    = 2'b00;
        s2   = 1'b0;
        case (state)
            LOAD_A: begin
                s1 = 2'b11;
                we = 1'b1;
                wa = RA_A;
            end
            LOAD_B: begin
                s1 = 2'b10;
                we = 1'b1;
                wa = RA_B;
            end
            EXEC: begin
                rea = 1'b1;
                raa = RA_A;
                reb = 1'b1;
                rab = RA_B;
                c   = op_q;
                s1  = 2'b00;
                we  = 1'b1;
                wa  = RA_Y;
            end
            OUT: begin
                rea  = 1'b1;
                raa  = RA_A;
                reb  = 1'b1;
                rab  = RA_B;
                c    = op_q;
                s2   = 1'b1;
                done = 1'b1;
            end
`ifdef CTRL_CLEAR_EN
            CLR: begin
                s1 = 2'b01;
                we = 1'b1;
                wa = cnt;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl; a small datapath model (mux, 4x3 register file, ALU, output gate) turns
// the control pins into a result value that is compared with hand-computed constants.
module tb_calc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       go;
    logic [1:0] op;
    logic       busy, done, we, rea, reb, s2;
    logic [1:0] s1, wa, raa, rab, c;
`ifdef CTRL_CLEAR_EN
    logic       clr;
`endif

    logic [2:0] in1, in2;
    logic [2:0] rf [4];
    logic       preload;
    logic [2:0] preload_val [4];
    logic [2:0] rd_a, rd_b, alu_y, wr_data, dp_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    calc_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .go   (go),
`ifdef CTRL_CLEAR_EN
        .clr  (clr),
`endif
        .op   (op),
        .busy (busy),
        .done (done),
        .s1   (s1),
        .we   (we),
        .wa   (wa),
        .rea  (rea),
        .raa  (raa),
        .reb  (reb),
        .rab  (rab),
        .c    (c),
        .s2   (s2)
    );

    // Datapath model: register file is never cleared by reset
    always_comb begin
        rd_a = rea ? rf[raa] : 3'd0;
        rd_b = reb ? rf[rab] : 3'd0;
        case (c)
            2'b00:   alu_y = rd_a + rd_b;
            2'b01:   alu_y = rd_a - rd_b;
            2'b10:   alu_y = rd_a & rd_b;
            default: alu_y = rd_a ^ rd_b;
        endcase
        case (s1)
            2'b11:   wr_data = in1;
            2'b10:   wr_data = in2;
            2'b01:   wr_data = 3'd0;
            default: wr_data = alu_y;
        endcase
        dp_out = s2 ? alu_y : 3'd0;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4; i++)
                rf[i] <= preload_val[i];
        end else if (we) begin
            rf[wa] <= wr_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drives one go pulse; returns at the negedge inside the LOAD_A cycle
    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic [1:0] o);
        @(negedge clk);
        in1 = a;
        in2 = b;
        op  = o;
        go  = 1'b1;
        @(negedge clk);
        go  = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] o, input logic [2:0] exp_y, input bit second_go);
        applyStimulus(a, b, o);
        checkOutput({tag, "_la_busy"}, busy, 1);
        checkOutput({tag, "_la_s1"}, s1, 3);
        checkOutput({tag, "_la_wa"}, wa, 1);
        @(negedge clk);
        checkOutput({tag, "_lb_s1"}, s1, 2);
        checkOutput({tag, "_lb_wa"}, wa, 2);
        if (second_go) begin
            go = 1'b1;
            op = 2'b00;
        end
        @(negedge clk);
        go = 1'b0;
        checkOutput({tag, "_ex_we_wa"}, {we, wa, s1}, {1'b1, 2'd3, 2'b00});
        checkOutput({tag, "_ex_c"}, c, o);
        checkOutput({tag, "_ex_done"}, done, 0);
        @(negedge clk);
        checkOutput({tag, "_out_done"}, done, 1);
        checkOutput({tag, "_out_y"}, dp_out, exp_y);
        checkOutput({tag, "_out_we"}, we, 0);
        @(negedge clk);
        checkOutput({tag, "_idle_busy"}, busy, 0);
        checkOutput({tag, "_idle_done"}, done, 0);
        checkOutput({tag, "_r3"}, rf[3], exp_y);
    endtask

    initial begin
        rst_n   = 1'b0;
        go      = 1'b0;
        op      = 2'b00;
        in1     = 3'd0;
        in2     = 3'd0;
        preload = 1'b1;
        for (int i = 0; i < 4; i++) preload_val[i] = 3'd0;
`ifdef CTRL_CLEAR_EN
        clr     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        preload = 1'b0;
        checkOutput("rst_busy_done", {busy, done}, 0);
        checkOutput("rst_s1", s1, 1);
        checkOutput("rst_ctrl", {we, wa, rea, raa, reb, rab, c, s2}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_rst", {busy, we, s1}, {1'b0, 1'b0, 2'b01});

        $display("[TB] test 1: add wraps");
        runOp("t1", 3'd3, 3'd5, 2'b00, 3'd0, 1'b0);

        $display("[TB] test 2: sub and and");
        runOp("t2a", 3'd2, 3'd5, 2'b01, 3'd5, 1'b0);
        runOp("t2b", 3'd6, 3'd3, 2'b10, 3'd2, 1'b0);

        $display("[TB] test 3: go while busy ignored");
        runOp("t3", 3'd6, 3'd3, 2'b11, 3'd5, 1'b1);
        @(negedge clk);
        checkOutput("t3_not_queued", busy, 0);

        $display("[TB] test 4: reset mid LOAD_B");
        applyStimulus(3'd1, 3'd1, 2'b00);
        @(negedge clk);
        checkOutput("t4_in_lb", s1, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("t4_abort", {busy, we, s1, done}, {1'b0, 1'b0, 2'b01, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("t4_r2_kept", rf[2], 3);
        checkOutput("t4_r1_loaded", rf[1], 1);
        runOp("t4", 3'd1, 3'd1, 2'b00, 3'd2, 1'b0);

        $display("[TB] test 5: go held high");
        @(negedge clk);
        in1 = 3'd1;
        in2 = 3'd2;
        op  = 2'b00;
        go  = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 12) go = 1'b0;
            checkOutput($sformatf("t5_done_%0d", i), done, (i == 4 || i == 9 || i == 14) ? 1 : 0);
            checkOutput($sformatf("t5_busy_%0d", i), busy, (i == 5 || i == 10) ? 0 : 1);
            if (i == 4 || i == 9 || i == 14)
                checkOutput($sformatf("t5_y_%0d", i), dp_out, 3);
        end

`ifdef CTRL_CLEAR_EN
        $display("[TB] test 6: clear sequence");
        @(negedge clk);
        for (int i = 0; i < 4; i++) preload_val[i] = 3'(i + 4);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        checkOutput("t6_preload_r0", rf[0], 4);
        clr = 1'b1;
        go  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clr = 1'b0;
            checkOutput($sformatf("t6_clr_%0d", i), {busy, we, wa, s1, done},
                        {1'b1, 1'b1, 2'(i), 2'b01, 1'b0});
        end
        go = 1'b0;
        @(negedge clk);
        checkOutput("t6_idle", {busy, done}, 0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t6_r%0d", i), rf[i], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
